// File: rtl/neopixel_controller_if.sv
// Host-side load/send handshake and strip status bundle for neopixel_controller.
interface neopixel_controller_if;
   logic       load_color;
   logic [2:0] pixel_index;
   logic [1:0] color_index;
   logic [7:0] color_level;
   logic       send_it;
   logic       ready_to_load;
   logic       ready_to_send;
   logic       begin_send;
   logic       done_send;
   logic       done_wait;
   logic       neo_data;

   modport master (
      output load_color,
      output pixel_index,
      output color_index,
      output color_level,
      output send_it,
      input  ready_to_load,
      input  ready_to_send,
      input  begin_send,
      input  done_send,
      input  done_wait,
      input  neo_data
   );

   modport slave (
      input  load_color,
      input  pixel_index,
      input  color_index,
      input  color_level,
      input  send_it,
      output ready_to_load,
      output ready_to_send,
      output begin_send,
      output done_send,
      output done_wait,
      output neo_data
   );
endinterface

// File: rtl/neopixel_controller.sv
// WS2812-style strip driver with a per-pixel RGB buffer sent as GRB, MSB first.
// Define NEO_CLEAR_AFTER_SEND_EN to wipe the buffer when a frame completes.
module neopixel_controller #(
   parameter int NUM_PIXELS   = 5,
   parameter int BIT_CYCLES   = 63,
   parameter int T0H_CYCLES   = 18,
   parameter int T1H_CYCLES   = 35,
   parameter int LATCH_CYCLES = 2500
) (
   input  logic                  clock,
   input  logic                  reset,
   neopixel_controller_if.slave  bus
);
   localparam int CW = $clog2(BIT_CYCLES + 1);
   localparam int LW = $clog2(LATCH_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      LATCH
   } state_t;

   state_t        r_state;
   state_t        w_next;

   logic [7:0]    r_buf [NUM_PIXELS][3];
   logic [CW-1:0] r_cyc;
   logic [2:0]    r_bit;
   logic [1:0]    r_byte;
   logic [2:0]    r_pix;
   logic [LW-1:0] r_lat;

   logic          r_neo;
   logic          r_begin;
   logic          r_done_send;
   logic          r_done_wait;
   logic          r_ready;

   logic [1:0]    w_col;
   logic [7:0]    w_byte;
   logic          w_bit;
   logic          w_high;
   logic          w_wr;
   logic          w_last;
   logic          w_bit_end;
   logic          w_frame_end;
   logic          w_lat_end;

   // Wire order is green, red, blue; buffer columns are red, green, blue.
   always_comb begin
      w_col = 2'd1;
      unique case (r_byte)
         2'd0:    w_col = 2'd1;
         2'd1:    w_col = 2'd0;
         default: w_col = 2'd2;
      endcase
   end

   assign w_byte      = r_buf[r_pix][w_col];
   assign w_bit       = w_byte[3'd7 - r_bit];
   assign w_high      = 32'(r_cyc) < (w_bit ? T1H_CYCLES : T0H_CYCLES);
   assign w_last      = (32'(r_pix) == NUM_PIXELS - 1) &&
                        (r_byte == 2'd2) && (r_bit == 3'd7);
   assign w_bit_end   = 32'(r_cyc) == BIT_CYCLES - 1;
   // Only the final bit runs one count further so its low tail finishes
   // on the line before the frame is declared done.
   assign w_frame_end = 32'(r_cyc) == BIT_CYCLES;
   assign w_lat_end   = 32'(r_lat) == LATCH_CYCLES - 1;

   assign w_wr = (r_state == IDLE) && bus.load_color &&
                 (32'(bus.pixel_index) < NUM_PIXELS) &&
                 (bus.color_index != 2'd3);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (bus.send_it) w_next = SEND;
         SEND:    if (w_frame_end) w_next = LATCH;
         LATCH:   if (w_lat_end)   w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cyc  <= '0;
         r_bit  <= '0;
         r_byte <= '0;
         r_pix  <= '0;
         r_lat  <= '0;
      end else begin
         unique case (r_state)
            SEND: begin
               r_lat <= '0;
               if (w_bit_end && !w_last) begin
                  r_cyc <= '0;
                  if (r_bit == 3'd7) begin
                     r_bit <= '0;
                     if (r_byte == 2'd2) begin
                        r_byte <= '0;
                        r_pix  <= r_pix + 3'd1;
                     end else begin
                        r_byte <= r_byte + 2'd1;
                     end
                  end else begin
                     r_bit <= r_bit + 3'd1;
                  end
               end else if (!w_frame_end) begin
                  r_cyc <= r_cyc + 1'b1;
               end
            end
            LATCH: begin
               r_cyc  <= '0;
               r_bit  <= '0;
               r_byte <= '0;
               r_pix  <= '0;
               r_lat  <= r_lat + 1'b1;
            end
            default: begin
               r_cyc  <= '0;
               r_bit  <= '0;
               r_byte <= '0;
               r_pix  <= '0;
               r_lat  <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_neo       <= 1'b0;
         r_begin     <= 1'b0;
         r_done_send <= 1'b0;
         r_done_wait <= 1'b0;
         r_ready     <= 1'b0;
      end else begin
         r_neo       <= (r_state == SEND) && !w_frame_end && w_high;
         r_begin     <= (r_state == IDLE) && bus.send_it;
         r_done_send <= (r_state == SEND) && w_frame_end;
         r_done_wait <= (r_state == LATCH) && w_lat_end;
         r_ready     <= (w_next == IDLE);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < NUM_PIXELS; p++) begin
            for (int c = 0; c < 3; c++) begin
               r_buf[p][c] <= 8'h00;
            end
         end
      end else begin
         if (w_wr) begin
            r_buf[bus.pixel_index][bus.color_index] <= bus.color_level;
         end
`ifdef NEO_CLEAR_AFTER_SEND_EN
         if ((r_state == SEND) && w_frame_end) begin
            for (int p = 0; p < NUM_PIXELS; p++) begin
               for (int c = 0; c < 3; c++) begin
                  r_buf[p][c] <= 8'h00;
               end
            end
         end
`endif
      end
   end

   assign bus.neo_data      = r_neo;
   assign bus.begin_send    = r_begin;
   assign bus.done_send     = r_done_send;
   assign bus.done_wait     = r_done_wait;
   assign bus.ready_to_load = r_ready;
   assign bus.ready_to_send = r_ready;

endmodule

// File: tb/tb_neopixel_controller.sv
// Scoreboard bench for neopixel_controller: expected bit stream queued at send,
// line monitor measures every high/low run and the latch window.
module tb_neopixel_controller;
   localparam int NP = 5;
   localparam int BC = 63;
   localparam int T0 = 18;
   localparam int T1 = 35;
   localparam int LC = 2500;
   localparam int NB = NP * 24;

   logic clock = 1'b0;
   logic reset = 1'b0;

   neopixel_controller_if bus ();

   neopixel_controller #(
      .NUM_PIXELS  (NP),
      .BIT_CYCLES  (BC),
      .T0H_CYCLES  (T0),
      .T1H_CYCLES  (T1),
      .LATCH_CYCLES(LC)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   bit exp_q[$];
   bit armed = 1'b0;
   int frames_done = 0;
   int pulse_total = 0;

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   // Line monitor: sampled on the falling edge, away from the active edge.
   int hi_cnt, lo_cnt, lat_cnt;
   bit prev_neo, cur_bit, have_bit, in_latch, prev_pulse;

   always @(negedge clock) begin
      if (!reset) begin
         hi_cnt     = 0;
         lo_cnt     = 0;
         lat_cnt    = 0;
         prev_neo   = 1'b0;
         have_bit   = 1'b0;
         in_latch   = 1'b0;
         prev_pulse = 1'b0;
      end else begin
         if (in_latch) lat_cnt++;
         if (bus.begin_send || bus.done_send || bus.done_wait) begin
            check("pulse_overlap", int'(bus.begin_send) + int'(bus.done_send)
                  + int'(bus.done_wait), 1);
            check("pulse_width", prev_pulse, 0);
         end
         prev_pulse = bus.begin_send | bus.done_send | bus.done_wait;
         if (bus.begin_send) check("begin_armed", armed, 1);
         if (bus.done_send) begin
            pulse_total++;
            check("done_send_armed", armed, 1);
            check("last_bit_seen", have_bit, 1);
            if (have_bit) check("last_bit_low", lo_cnt, BC - (cur_bit ? T1 : T0));
            check("bits_left", exp_q.size(), 0);
            have_bit = 1'b0;
            in_latch = 1'b1;
            lat_cnt  = 0;
         end
         if (bus.done_wait) begin
            pulse_total++;
            check("done_wait_after_send", in_latch, 1);
            check("latch_len", lat_cnt, LC);
            in_latch = 1'b0;
            armed    = 1'b0;
            frames_done++;
         end
         if (bus.neo_data) begin
            if (!prev_neo) begin
               if (have_bit) check("bit_low", lo_cnt, BC - (cur_bit ? T1 : T0));
               have_bit = 1'b0;
               hi_cnt   = 0;
            end
            hi_cnt++;
            if (in_latch) check("latch_line_low", bus.neo_data, 0);
         end else begin
            if (prev_neo) begin
               check("bit_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  cur_bit = exp_q.pop_front();
                  check("bit_high", hi_cnt, cur_bit ? T1 : T0);
                  have_bit = 1'b1;
               end
               lo_cnt = 0;
            end
            lo_cnt++;
         end
         prev_neo = bus.neo_data;
      end
   end

   task automatic load(input logic [2:0] p, input logic [1:0] c, input logic [7:0] v);
      @(posedge clock);
      #1;
      bus.load_color  = 1'b1;
      bus.pixel_index = p;
      bus.color_index = c;
      bus.color_level = v;
      @(posedge clock);
      #1;
      bus.load_color = 1'b0;
   endtask

   task automatic send_frame(input logic [NB-1:0] v, input bit wr,
                             input logic [2:0] p, input logic [1:0] c,
                             input logic [7:0] lvl);
      for (int i = 0; i < NB; i++) exp_q.push_back(v[i]);
      armed = 1'b1;
      @(posedge clock);
      #1;
      check("ready_load_idle", bus.ready_to_load, 1);
      bus.send_it = 1'b1;
      if (wr) begin
         bus.load_color  = 1'b1;
         bus.pixel_index = p;
         bus.color_index = c;
         bus.color_level = lvl;
      end
      @(posedge clock);
      #1;
      bus.send_it    = 1'b0;
      bus.load_color = 1'b0;
      check("begin_send", bus.begin_send, 1);
      check("ready_send_busy", bus.ready_to_send, 0);
      check("neo_before_latency", bus.neo_data, 0);
      @(posedge clock);
      #1;
      check("neo_latency", bus.neo_data, 1);
      check("begin_one_cycle", bus.begin_send, 0);
      check("ready_load_busy", bus.ready_to_load, 0);
   endtask

   task automatic wait_frame(input string name);
      int  start;
      bit  got;
      start = frames_done;
      got   = 1'b0;
      for (int i = 0; i < 11000; i++) begin
         @(posedge clock);
         if (frames_done != start) begin
            got = 1'b1;
            break;
         end
      end
      check(name, got, 1);
      #1;
      check("ready_after_frame", bus.ready_to_send & bus.ready_to_load, 1);
   endtask

   task automatic do_reset();
      @(posedge clock);
      #3;
      reset = 1'b0;
      exp_q.delete();
      armed = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("ready_after_reset", bus.ready_to_load & bus.ready_to_send, 1);
   endtask

   logic [NB-1:0] v;
   int            p0;

   initial begin
      bus.load_color  = 1'b0;
      bus.pixel_index = 3'd0;
      bus.color_index = 2'd0;
      bus.color_level = 8'h00;
      bus.send_it     = 1'b0;

      repeat (3) @(posedge clock);
      #1;
      check("rst_neo", bus.neo_data, 0);
      check("rst_pulses", int'(bus.begin_send) + int'(bus.done_send)
            + int'(bus.done_wait), 0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("rst_ready_load", bus.ready_to_load, 1);
      check("rst_ready_send", bus.ready_to_send, 1);

      // Empty buffer: 120 zero bits.
      send_frame('0, 1'b0, 3'd0, 2'd0, 8'h00);
      wait_frame("frame_empty");

      // Pixel 0 green=0x80, red=0x01: bits 0 and 15 are ones.
      load(3'd0, 2'd1, 8'h80);
      load(3'd0, 2'd0, 8'h01);
      v = '0;
      v[0]  = 1'b1;
      v[15] = 1'b1;
      send_frame(v, 1'b0, 3'd0, 2'd0, 8'h00);
      wait_frame("frame_p0");

      // Out-of-range pixel and color index 3 must not write.
      do_reset();
      load(3'd5, 2'd0, 8'hFF);
      load(3'd1, 2'd3, 8'hFF);
      send_frame('0, 1'b0, 3'd0, 2'd0, 8'h00);
      wait_frame("frame_badidx");

      // Write in the send cycle, then a write while busy that must be dropped.
      do_reset();
      v = '0;
      v[119:112] = 8'hFF;
      send_frame(v, 1'b1, 3'd4, 2'd2, 8'hFF);
      load(3'd0, 2'd0, 8'hAA);
      wait_frame("frame_same_cycle");
`ifdef NEO_CLEAR_AFTER_SEND_EN
      v = '0;
`endif
      send_frame(v, 1'b0, 3'd0, 2'd0, 8'h00);
      wait_frame("frame_after_busy_load");

      // Abort around bit 60.
      send_frame('0, 1'b0, 3'd0, 2'd0, 8'h00);
      repeat (59 * BC + 10) @(posedge clock);
      #3;
      reset = 1'b0;
      exp_q.delete();
      armed = 1'b0;
      p0 = pulse_total;
      #1;
      check("abort_neo_low", bus.neo_data, 0);
      check("abort_pulses_low", int'(bus.begin_send) + int'(bus.done_send)
            + int'(bus.done_wait), 0);
      repeat (4) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("abort_ready", bus.ready_to_load & bus.ready_to_send, 1);
      repeat (6500) @(posedge clock);
      #1;
      check("abort_no_done", pulse_total - p0, 0);
      check("abort_line_idle", bus.neo_data, 0);

      // Pixel 2 red=0x16 over two back-to-back frames.
      load(3'd2, 2'd0, 8'h16);
      v = '0;
      v[59] = 1'b1;
      v[61] = 1'b1;
      v[62] = 1'b1;
      send_frame(v, 1'b0, 3'd0, 2'd0, 8'h00);
      wait_frame("frame_red16_a");
`ifdef NEO_CLEAR_AFTER_SEND_EN
      v = '0;
`endif
      send_frame(v, 1'b0, 3'd0, 2'd0, 8'h00);
      wait_frame("frame_red16_b");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
